// File: rtl/alu_decoder.sv
// ALU-control decoder: maps ALUOpcode/funct3/funct7[5]/opcode[5] to ALUControl.
// Optional macro ALU_DECODER_REG_OUT_EN registers ALUControl and Illegal.
module alu_decoder #(
    parameter logic [2:0] ILLEGAL_CTRL = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ALUOpcode,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       opcode5,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic       IllegalSticky
);

    logic [2:0] ctrl_comb;
    logic       illegal_comb;

    // Decode operation class and function fields into the ALU select
    always_comb begin
        ctrl_comb    = ILLEGAL_CTRL;
        illegal_comb = 1'b0;
        case (ALUOpcode)
            2'b00: ctrl_comb = 3'b000;
            2'b01: ctrl_comb = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000: ctrl_comb = (opcode5 & funct7) ? 3'b001 : 3'b000;
                    3'b010: ctrl_comb = 3'b101;
                    3'b110: ctrl_comb = 3'b011;
                    3'b111: ctrl_comb = 3'b010;
                    default: begin
                        ctrl_comb    = ILLEGAL_CTRL;
                        illegal_comb = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl_comb    = ILLEGAL_CTRL;
                illegal_comb = 1'b1;
            end
        endcase
    end

    // Sticky debug flag: reset wins, otherwise latch any illegal encoding
    always_ff @(posedge clk) begin
        if (reset) begin
            IllegalSticky <= 1'b0;
        end else if (illegal_comb) begin
            IllegalSticky <= 1'b1;
        end
    end

`ifdef ALU_DECODER_REG_OUT_EN
    logic [2:0] ctrl_q;
    logic       illegal_q;

    // Register decoded outputs for a one-cycle-latency variant
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= 3'b000;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_comb;
            illegal_q <= illegal_comb;
        end
    end

    assign ALUControl = ctrl_q;
    assign Illegal    = illegal_q;
`else
    assign ALUControl = ctrl_comb;
    assign Illegal    = illegal_comb;
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// Directed testbench for alu_decoder (default combinational build).
// Expected values are hand-computed from the ALU control encoding table.
module tb_alu_decoder;

    logic       clk;
    logic       reset;
    logic [1:0] ALUOpcode;
    logic [2:0] funct3;
    logic       funct7;
    logic       opcode5;
    logic [2:0] ALUControl;
    logic       Illegal;
    logic       IllegalSticky;

    int n_vec;
    int n_bad;

    alu_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .ALUOpcode    (ALUOpcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .opcode5      (opcode5),
        .ALUControl   (ALUControl),
        .Illegal      (Illegal),
        .IllegalSticky(IllegalSticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [1:0] op, input logic [2:0] f3,
                         input logic f7, input logic o5);
        ALUOpcode = op;
        funct3    = f3;
        funct7    = f7;
        opcode5   = o5;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        ALUOpcode = 2'b00;
        funct3 = 3'b000;
        funct7 = 1'b0;
        opcode5 = 1'b0;

        @(posedge clk);
        #1;
        check("rst_sticky", {7'd0, IllegalSticky}, 8'd0);
        check("rst_ctrl", {5'd0, ALUControl}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        apply(2'b00, 3'b111, 1'b1, 1'b1);
        check("ld_a_ctrl", {5'd0, ALUControl}, 8'd0);
        check("ld_a_ill", {7'd0, Illegal}, 8'd0);
        apply(2'b00, 3'b000, 1'b0, 1'b0);
        check("ld_b_ctrl", {5'd0, ALUControl}, 8'd0);
        check("ld_b_ill", {7'd0, Illegal}, 8'd0);

        apply(2'b01, 3'b111, 1'b1, 1'b1);
        check("br_ctrl", {5'd0, ALUControl}, 8'd1);
        check("br_ill", {7'd0, Illegal}, 8'd0);

        apply(2'b10, 3'b000, 1'b0, 1'b0);
        check("add_00", {5'd0, ALUControl}, 8'd0);
        apply(2'b10, 3'b000, 1'b0, 1'b1);
        check("add_10", {5'd0, ALUControl}, 8'd0);
        apply(2'b10, 3'b000, 1'b1, 1'b0);
        check("add_01", {5'd0, ALUControl}, 8'd0);
        apply(2'b10, 3'b000, 1'b1, 1'b1);
        check("sub_11", {5'd0, ALUControl}, 8'd1);
        check("sub_ill", {7'd0, Illegal}, 8'd0);

        @(negedge clk);
        apply(2'b10, 3'b010, 1'b1, 1'b1);
        check("slt", {5'd0, ALUControl}, 8'd5);
        apply(2'b10, 3'b110, 1'b1, 1'b1);
        check("or", {5'd0, ALUControl}, 8'd3);
        apply(2'b10, 3'b111, 1'b1, 1'b1);
        check("and", {5'd0, ALUControl}, 8'd2);
        check("and_ill", {7'd0, Illegal}, 8'd0);
        apply(2'b10, 3'b010, 1'b0, 1'b0);
        check("slti", {5'd0, ALUControl}, 8'd5);
        check("clean_sticky", {7'd0, IllegalSticky}, 8'd0);

        @(negedge clk);
        apply(2'b10, 3'b100, 1'b0, 1'b0);
        check("ill_ctrl", {5'd0, ALUControl}, 8'd0);
        check("ill_now", {7'd0, Illegal}, 8'd1);
        check("ill_pre_edge", {7'd0, IllegalSticky}, 8'd0);
        @(posedge clk);
        #1;
        check("ill_sticky", {7'd0, IllegalSticky}, 8'd1);

        @(negedge clk);
        apply(2'b00, 3'b000, 1'b0, 1'b0);
        check("legal_ill", {7'd0, Illegal}, 8'd0);
        @(posedge clk);
        #1;
        check("sticky_hold", {7'd0, IllegalSticky}, 8'd1);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("sticky_clr", {7'd0, IllegalSticky}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        begin
            logic [2:0] bad_f3 [4];
            bad_f3[0] = 3'b001;
            bad_f3[1] = 3'b011;
            bad_f3[2] = 3'b100;
            bad_f3[3] = 3'b101;
            for (int i = 0; i < 4; i++) begin
                apply(2'b10, bad_f3[i], 1'b1, 1'b1);
                check($sformatf("bad_f3_%0d_ill", bad_f3[i]),
                      {7'd0, Illegal}, 8'd1);
                check($sformatf("bad_f3_%0d_ctrl", bad_f3[i]),
                      {5'd0, ALUControl}, 8'd0);
            end
        end

        @(negedge clk);
        reset = 1'b1;
        apply(2'b00, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_prio_clr", {7'd0, IllegalSticky}, 8'd0);

        @(negedge clk);
        reset = 1'b0;
        apply(2'b11, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("op11_sticky", {7'd0, IllegalSticky}, 8'd1);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("prio_sticky", {7'd0, IllegalSticky}, 8'd0);
        check("prio_ill", {7'd0, Illegal}, 8'd1);
        check("prio_ctrl", {5'd0, ALUControl}, 8'd0);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_prio", {7'd0, IllegalSticky}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_decoder.md
Name: alu_decoder

Overview:
- ALU-control decoder inside the single-cycle core's control unit, beside the main decoder.
- Maps the 2-bit ALUOpcode from the main decoder, plus instruction fields funct3, funct7[5] and opcode[5], to the 3-bit ALUControl that drives the ALU.
- The decode path is purely combinational, so the datapath sees ALUControl within the same cycle.
- One clocked status flag records unsupported encodings for debug.

Parameters:
- ILLEGAL_CTRL, 3'b000, ALUControl value driven for any unsupported encoding (add, so the ALU output is harmless).

Ports:
- clk  input  1  core clock; used only by status and optional output registers
- reset  input  1  synchronous, active-high reset
- ALUOpcode  input  2  ALU operation class from the main decoder
- funct3  input  3  instruction bits [14:12]
- funct7  input  1  instruction bit 30 (funct7[5])
- opcode5  input  1  instruction bit 5 (opcode[5]); 1 = R-type, 0 = I-type
- ALUControl  output  3  ALU operation select
- Illegal  output  1  combinational; high when the current inputs hit an unsupported encoding
- IllegalSticky  output  1  registered; set on any clock edge where Illegal is high

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- ALUControl encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ALUOpcode=00 (load/store/addr): ALUControl=000 regardless of funct3, funct7 and opcode5; Illegal=0.
- ALUOpcode=01 (branch compare): ALUControl=001 regardless of the other inputs; Illegal=0.
- ALUOpcode=10 (R/I arithmetic) decodes on funct3:
  - 000: ALUControl=001 (sub) only when opcode5=1 and funct7=1; otherwise 000 (add/addi). Covers all of {00,01,10}.
  - 010: 101 (slt/slti). funct7 and opcode5 ignored.
  - 110: 011 (or/ori).
  - 111: 010 (and/andi).
  - 001, 011, 100, 101: ALUControl=ILLEGAL_CTRL, Illegal=1.
- ALUOpcode=11: reserved; ALUControl=ILLEGAL_CTRL, Illegal=1.
- Decode is fully combinational, with zero latency from any input to ALUControl and Illegal.
- The decode never produces X for known inputs. Every case has an explicit default, and no latches are inferred.
- IllegalSticky:
  - Cleared to 0 on a rising clk edge with reset=1.
  - Otherwise set to 1 on a rising edge where Illegal=1, and holds until the next reset.
  - Reset has priority when reset=1 and Illegal=1 on the same edge (result 0).
- ALUControl and Illegal are not affected by reset in the default build; they follow the inputs even while reset is high.

Optional Feature:
- Macro ALU_DECODER_REG_OUT_EN.
- Defined:
  - ALUControl and Illegal are registered on the rising clk edge, giving 1-cycle latency from inputs.
  - reset=1 drives both to 000/0 on the next edge.
  - IllegalSticky samples the combinational (pre-register) Illegal.
- Undefined (default): outputs are combinational as described above. The single-cycle core requires this default.

Test Plan:
- ALUOpcode=00 with funct3=111, funct7=1, opcode5=1, then with funct3=000, funct7=0, opcode5=0 -> ALUControl=000 both times, Illegal=0.
- ALUOpcode=01, funct3=111, funct7=1, opcode5=1 -> ALUControl=001.
- ALUOpcode=10, funct3=000, {opcode5,funct7} swept 00, 10, 01, 11 -> ALUControl=000, 000, 000, 001.
- ALUOpcode=10, funct7=1, opcode5=1, funct3=010/110/111 -> ALUControl=101/011/010, each checked 1 time unit after the input change with no clock edge.
- Illegal path:
  - Apply ALUOpcode=10, funct3=100 -> ALUControl=000, Illegal=1 immediately.
  - After one clk edge -> IllegalSticky=1.
  - Return to a legal encoding -> IllegalSticky stays 1.
  - Apply reset=1 for one edge -> IllegalSticky=0.
- Reset priority: reset=1 with ALUOpcode=11 held across an edge -> IllegalSticky=0, Illegal=1, ALUControl=000.
